// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS-style datapath.
// Outputs decode the state register; Fetch enables also follow MemReady.
module multicycle_control (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] Op,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic       IllegalOp,
  output logic [3:0] State
);

  localparam logic [3:0] S_FETCH = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MADDR = 4'd2;
  localparam logic [3:0] S_MRD = 4'd3;
  localparam logic [3:0] S_MWB = 4'd4;
  localparam logic [3:0] S_MWR = 4'd5;
  localparam logic [3:0] S_EXEC = 4'd6;
  localparam logic [3:0] S_RWB = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP = 4'd9;

  logic [3:0] state_q, state_d;
  logic op_r, op_lw, op_sw, op_beq, op_j, op_ok;

  assign op_r   = (Op == 6'b000000);
  assign op_lw  = (Op == 6'b100011);
  assign op_sw  = (Op == 6'b101011);
  assign op_beq = (Op == 6'b000100);
  assign op_j   = (Op == 6'b000010);
  assign op_ok  = op_r | op_lw | op_sw | op_beq | op_j;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (op_lw || op_sw) state_d = S_MADDR;
        else if (op_r)      state_d = S_EXEC;
        else if (op_beq)    state_d = S_BRANCH;
        else if (op_j)      state_d = S_JUMP;
        else                state_d = S_FETCH;
      end
      S_MADDR:  state_d = op_lw ? S_MRD : S_MWR;
      S_MRD:    state_d = MemReady ? S_MWB : S_MRD;
      S_MWR:    state_d = MemReady ? S_FETCH : S_MWR;
      S_EXEC:   state_d = S_RWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Raw decode; write enables are masked by Reset below.
  logic pcw_r, pcwc_r, irw_r, regw_r, memw_r;

  always_comb begin
    pcw_r     = 1'b0;
    pcwc_r    = 1'b0;
    irw_r     = 1'b0;
    regw_r    = 1'b0;
    memw_r    = 1'b0;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemtoReg  = 1'b0;
    ALUSrcA   = 1'b0;
    RegDst    = 1'b0;
    ALUOp     = 2'b00;
    ALUSrcB   = 2'b00;
    PCSource  = 2'b00;
    IllegalOp = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        irw_r   = MemReady;
        pcw_r   = MemReady;
        ALUSrcB = 2'b01;
      end
      S_DECODE: begin
        ALUSrcB   = 2'b11;
        IllegalOp = ~op_ok;
      end
      S_MADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MWB: begin
        regw_r   = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MWR: begin
        memw_r = 1'b1;
        IorD   = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_RWB: begin
        regw_r = 1'b1;
        RegDst = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 2'b01;
        pcwc_r   = 1'b1;
        PCSource = 2'b01;
      end
      S_JUMP: begin
        pcw_r    = 1'b1;
        PCSource = 2'b10;
      end
      default: ;
    endcase
  end

  assign PCWrite     = pcw_r & ~Reset;
  assign PCWriteCond = pcwc_r & ~Reset;
  assign IRWrite     = irw_r & ~Reset;
  assign RegWrite    = regw_r & ~Reset;
  assign MemWrite    = memw_r & ~Reset;
  assign State       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboarded bench for multicycle_control.
// Expected state/outputs per cycle come from the state table.
module tb_multicycle_control;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [5:0] Op;
  logic       MemReady;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
  logic       MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst;
  logic [1:0] ALUOp, ALUSrcB, PCSource;
  logic       IllegalOp;
  logic [3:0] State;

  multicycle_control dut (
    .Clk(Clk), .Reset(Reset), .Op(Op), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .IllegalOp(IllegalOp), .State(State)
  );

  always #5 Clk = ~Clk;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;

  typedef struct {
    logic [3:0]  st;
    logic [16:0] o;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,
  //  ALUSrcA,RegWrite,RegDst,ALUOp,ALUSrcB,PCSource,IllegalOp}
  function automatic logic [16:0] ref_out(input logic [3:0] st,
    input logic rst, input logic mr, input logic [5:0] op);
    logic pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, ill;
    logic [1:0] aop, asb, pcs;
    logic ok;
    {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, ill} = '0;
    aop = 2'b00; asb = 2'b00; pcs = 2'b00;
    ok = (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
         (op == OP_BEQ) || (op == OP_J);
    case (st)
      4'd0: begin mrd = 1; irw = mr; pcw = mr; asb = 2'b01; end
      4'd1: begin asb = 2'b11; ill = !ok; end
      4'd2: begin asa = 1; asb = 2'b10; end
      4'd3: begin mrd = 1; iord = 1; end
      4'd4: begin rw = 1; m2r = 1; end
      4'd5: begin mwr = 1; iord = 1; end
      4'd6: begin asa = 1; aop = 2'b10; end
      4'd7: begin rw = 1; rd = 1; end
      4'd8: begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      4'd9: begin pcw = 1; pcs = 2'b10; end
      default: ;
    endcase
    if (rst) begin
      pcw = 0; pcwc = 0; irw = 0; rw = 0; mwr = 0;
    end
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd,
            aop, asb, pcs, ill};
  endfunction

  // One cycle: drive inputs, push expectation, sample mid-cycle.
  task automatic step(input logic rst, input logic mr,
    input logic [5:0] op, input logic [3:0] est, input string tag);
    exp_t e, g;
    logic [16:0] act;
    @(negedge Clk);
    Reset = rst;
    MemReady = mr;
    Op = op;
    e.st = est;
    e.o = ref_out(est, rst, mr, op);
    e.tag = tag;
    exp_q.push_back(e);
    #1;
    g = exp_q.pop_front();
    act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
           IRWrite, ALUSrcA, RegWrite, RegDst, ALUOp, ALUSrcB,
           PCSource, IllegalOp};
    n_checks++;
    if (State !== g.st) begin
      n_fail++;
      $display("FAIL %s state: got %0d want %0d", g.tag, State, g.st);
    end
    n_checks++;
    if (act !== g.o) begin
      n_fail++;
      $display("FAIL %s outputs: got %b want %b", g.tag, act, g.o);
    end
  endtask

  task automatic test_reset;
    @(posedge Clk);
    step(1, 1, OP_LW, 4'd0, "rst_a");
    step(1, 0, OP_LW, 4'd0, "rst_b");
  endtask

  task automatic test_lw;
    step(0, 1, OP_LW, 4'd0, "lw_f");
    step(0, 1, OP_LW, 4'd1, "lw_d");
    step(0, 1, OP_LW, 4'd2, "lw_a");
    step(0, 1, OP_LW, 4'd3, "lw_r");
    step(0, 1, OP_LW, 4'd4, "lw_wb");
  endtask

  task automatic test_sw_wait;
    step(0, 1, OP_SW, 4'd0, "sw_f");
    step(0, 1, OP_SW, 4'd1, "sw_d");
    step(0, 1, OP_SW, 4'd2, "sw_a");
    for (int i = 0; i < 3; i++) step(0, 0, OP_SW, 4'd5, "sw_wait");
    step(0, 1, OP_SW, 4'd5, "sw_done");
  endtask

  task automatic test_rtype;
    step(0, 1, OP_R, 4'd0, "r_f");
    step(0, 1, OP_R, 4'd1, "r_d");
    step(0, 1, OP_R, 4'd6, "r_ex");
    step(0, 1, OP_R, 4'd7, "r_wb");
  endtask

  task automatic test_branch_jump;
    step(0, 1, OP_BEQ, 4'd0, "beq_f");
    step(0, 1, OP_BEQ, 4'd1, "beq_d");
    step(0, 1, OP_BEQ, 4'd8, "beq_br");
    step(0, 1, OP_J, 4'd0, "j_f");
    step(0, 1, OP_J, 4'd1, "j_d");
    step(0, 1, OP_J, 4'd9, "j_jmp");
  endtask

  task automatic test_illegal;
    step(0, 1, OP_BAD, 4'd0, "ill_f");
    step(0, 1, OP_BAD, 4'd1, "ill_d");
  endtask

  task automatic test_fetch_wait;
    step(0, 0, OP_J, 4'd0, "fw_0");
    step(0, 0, OP_J, 4'd0, "fw_1");
    step(0, 1, OP_J, 4'd0, "fw_go");
    step(0, 1, OP_J, 4'd1, "fw_d");
    step(0, 1, OP_J, 4'd9, "fw_j");
  endtask

  task automatic test_reset_midway;
    step(0, 1, OP_LW, 4'd0, "rm_f");
    step(0, 1, OP_LW, 4'd1, "rm_d");
    step(0, 1, OP_LW, 4'd2, "rm_a");
    step(0, 0, OP_LW, 4'd3, "rm_wait");
    step(1, 1, OP_LW, 4'd3, "rm_rst");
    step(0, 0, OP_LW, 4'd0, "rm_f0");
    step(0, 1, OP_LW, 4'd0, "rm_f1");
    step(0, 1, OP_LW, 4'd1, "rm_d1");
  endtask

  initial begin
    Reset = 1'b1;
    MemReady = 1'b0;
    Op = OP_LW;
    test_reset;
    test_lw;
    test_sw_wait;
    test_rtype;
    test_branch_jump;
    test_illegal;
    test_fetch_wait;
    test_reset_midway;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
